// File: rtl/fifo_burst_pkg.sv
// Shared types and helpers for the FWFT FIFO burst reader.
package fifo_burst_pkg;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  // Width of a counter that must reach v-1; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return $clog2(v) + 1;
  endfunction

endpackage

// File: rtl/fifo_burst_out_reg.sv
// Single-entry valid/ready output register: loads a beat, holds it until accepted.
module fifo_burst_out_reg #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  always_comb begin
    valid_d = valid_q && !ready_i;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/fifo_fwft_burst_reader.sv
// Drains a FWFT FIFO into framed valid/ready bursts; closes on length or empty timeout.
// Optional statistics counters are enabled with FIFO_BURST_READER_STATS_EN.
module fifo_fwft_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  output logic              fifo_rd_en_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
`ifdef FIFO_BURST_READER_STATS_EN
  output logic [31:0]       burst_count_o,
  output logic [31:0]       timeout_count_o,
`endif
  output logic              m_last_o,
  output logic              burst_open_o
);

  localparam int unsigned     BeatW    = clog2_min1(BURST_LEN);
  localparam int unsigned     IdleW    = clog2_min1(TIMEOUT);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
  logic              burst_open_q, burst_open_d;

  logic in_hold, slot_free, hit_len, hit_data, hit_idle, promote, last_next;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      hold_data_q  <= '0;
      beat_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      burst_open_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_data_q  <= hold_data_d;
      beat_cnt_q   <= beat_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      burst_open_q <= burst_open_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_data_d  = hold_data_q;
    beat_cnt_d   = beat_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    burst_open_d = burst_open_q;
    if (fifo_rd_en_o) hold_data_d = fifo_rd_data_i;
    unique case (state_q)
      StIdle: begin
        if (fifo_rd_en_o) begin
          state_d      = StHold;
          burst_open_d = 1'b1;
        end
      end
      StHold: begin
        // A promote without refill can only be a closing beat.
        if (promote && !fifo_rd_en_o) begin
          state_d      = StIdle;
          burst_open_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (promote) beat_cnt_d = last_next ? '0 : beat_cnt_q + BeatW'(1);
    if (promote || !fifo_empty_i) begin
      idle_cnt_d = '0;
    end else if (in_hold && idle_cnt_q != IdleLast) begin
      idle_cnt_d = idle_cnt_q + IdleW'(1);
    end
  end

  always_comb begin
    in_hold   = state_q == StHold;
    slot_free = !m_valid_o || m_ready_i;
    hit_len   = beat_cnt_q == BeatLast;
    hit_data  = !fifo_empty_i;
    hit_idle  = idle_cnt_q == IdleLast;
    promote   = in_hold && slot_free && (hit_len || hit_data || hit_idle);
    // Length limit beats a waiting next word; a fresh word overrides a stale timeout.
    last_next = hit_len || (hit_idle && !hit_data);
    fifo_rd_en_o = !rst_i && !fifo_empty_i &&
                   ((!in_hold && enable_i) || (promote && (!last_next || enable_i)));
  end

  assign burst_open_o = burst_open_q;

  fifo_burst_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (promote),
    .data_i (hold_data_q),
    .last_i (last_next),
    .ready_i(m_ready_i),
    .valid_o(m_valid_o),
    .data_o (m_data_o),
    .last_o (m_last_o)
  );

`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] burst_count_q, timeout_count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      burst_count_q   <= '0;
      timeout_count_q <= '0;
    end else begin
      if (m_valid_o && m_ready_i && m_last_o) burst_count_q <= burst_count_q + 32'd1;
      if (promote && hit_idle && !hit_len && !hit_data) begin
        timeout_count_q <= timeout_count_q + 32'd1;
      end
    end
  end

  assign burst_count_o   = burst_count_q;
  assign timeout_count_o = timeout_count_q;
`endif

endmodule

// File: tb/tb_fifo_fwft_burst_reader.sv
// Self-checking bench for fifo_fwft_burst_reader with BURST_LEN=4, TIMEOUT=32.
module tb_fifo_fwft_burst_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned BL = 4;
  localparam int unsigned TO = 32;

  logic          clk = 1'b0;
  logic          rst, enable, m_ready, flush;
  logic          fifo_empty, fifo_rd_en, m_valid, m_last, burst_open;
  logic [DW-1:0] fifo_rd_data, m_data;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0]   burst_count, timeout_count;
`endif

  // Behavioural FWFT FIFO: 256-entry ring, pointers wrap naturally.
  logic [DW-1:0] mem [256];
  logic [7:0]    wr_ptr = 8'd0;
  logic [7:0]    rd_ptr = 8'd0;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rd_data = mem[rd_ptr];

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
  end

  always #5 clk = ~clk;

  fifo_fwft_burst_reader #(
    .DATA_W   (DW),
    .BURST_LEN(BL),
    .TIMEOUT  (TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_rd_en_o   (fifo_rd_en),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_data_o       (m_data),
`ifdef FIFO_BURST_READER_STATS_EN
    .burst_count_o  (burst_count),
    .timeout_count_o(timeout_count),
`endif
    .m_last_o       (m_last),
    .burst_open_o   (burst_open)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Transfer monitor: records every accepted beat and checks stall stability.
  bit            mon_en = 1'b0;
  logic [DW-1:0] got_data [$];
  bit            got_last [$];
  bit            got_open [$];
  int            got_cyc  [$];
  int            cyc = 0;

  initial begin
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (fifo_empty) check("rd_en_while_empty", 32'(fifo_rd_en), 32'd0);
      if (mon_en) begin
        if (prev_stall) begin
          check("stall_valid", 32'(m_valid), 32'd1);
          check("stall_data", 32'(m_data), 32'(prev_data));
          check("stall_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && m_ready) begin
          got_data.push_back(m_data);
          got_last.push_back(m_last);
          got_open.push_back(burst_open);
          got_cyc.push_back(cyc);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    got_data.delete();
    got_last.delete();
    got_open.delete();
    got_cyc.delete();
  endtask

  task automatic start_reset();
    @(posedge clk); #1;
    rst    = 1'b1;
    flush  = 1'b1;
    mon_en = 1'b0;
    enable = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    mon_en = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int bound, input string name);
    int k = 0;
    while (got_data.size() < n && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, 32'(got_data.size()), 32'(n));
  endtask

  typedef struct {
    bit            en;
    bit            rdy;
    bit            rd;
    bit            v;
    logic [DW-1:0] d;
    bit            l;
    bit            o;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [7:0] base, rem;
    logic [DW-1:0] exp_q [$];
    int pushed, gap, k;

    // enable held low, then 8 prefilled words drain as two 4-beat bursts
    tbl[0]  = '{0, 1, 0, 0, 16'h0000, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 16'h0000, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 16'h0000, 0, 0};
    tbl[3]  = '{1, 1, 1, 0, 16'h0000, 0, 1};
    tbl[4]  = '{1, 1, 1, 1, 16'h0001, 0, 1};
    tbl[5]  = '{1, 1, 1, 1, 16'h0002, 0, 1};
    tbl[6]  = '{1, 1, 1, 1, 16'h0003, 0, 1};
    tbl[7]  = '{1, 1, 1, 1, 16'h0004, 1, 1};
    tbl[8]  = '{1, 1, 1, 1, 16'h0005, 0, 1};
    tbl[9]  = '{1, 1, 1, 1, 16'h0006, 0, 1};
    tbl[10] = '{1, 1, 0, 1, 16'h0007, 0, 1};
    tbl[11] = '{1, 1, 0, 1, 16'h0008, 1, 0};
    tbl[12] = '{1, 1, 0, 0, 16'h0008, 1, 0};

    rst = 1'b1; flush = 1'b1; enable = 1'b1; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 flush = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    @(negedge clk);
    check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    check("reset_valid", 32'(m_valid), 32'd0);
    check("reset_data", 32'(m_data), 32'd0);
    check("reset_last", 32'(m_last), 32'd0);
    check("reset_open", 32'(burst_open), 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i != 0) begin @(posedge clk); #1; end
      enable  = tbl[i].en;
      m_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("tbl%0d_rd_en", i), 32'(fifo_rd_en), 32'(tbl[i].rd));
      check($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].v));
      check($sformatf("tbl%0d_open", i), 32'(burst_open), 32'(tbl[i].o));
      if (tbl[i].v) begin
        check($sformatf("tbl%0d_data", i), 32'(m_data), 32'(tbl[i].d));
        check($sformatf("tbl%0d_last", i), 32'(m_last), 32'(tbl[i].l));
      end
    end

    // Trailing words closed by the empty timeout
    start_reset();
    push(16'h00A0); push(16'h00A1); push(16'h00A2);
    release_reset();
    enable = 1'b1;
    wait_beats(3, 80, "to_count");
    check("to_d0", 32'(got_data[0]), 32'h00A0);
    check("to_d1", 32'(got_data[1]), 32'h00A1);
    check("to_d2", 32'(got_data[2]), 32'h00A2);
    check("to_last01", 32'({got_last[0], got_last[1]}), 32'd0);
    check("to_last2", 32'(got_last[2]), 32'd1);
    check("to_back2back", 32'(got_cyc[1] - got_cyc[0]), 32'd1);
    check("to_delay", 32'(got_cyc[2] - got_cyc[1]), 32'(TO));
    check("to_open_after", 32'(got_open[2]), 32'd0);

    // enable dropped mid-burst: burst still runs to BURST_LEN, nothing more starts
    start_reset();
    for (int i = 0; i < 6; i++) push(DW'(16'h0010 + i));
    release_reset();
    enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("en_count", 32'(got_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("en_d%0d", i), 32'(got_data[i]), 32'(16'h0010 + i));
      check($sformatf("en_l%0d", i), 32'(got_last[i]), 32'(i == 3));
    end
    check("en_left", 32'(wr_ptr - rd_ptr), 32'd2);
    check("en_idle_valid", 32'(m_valid), 32'd0);
    check("en_idle_open", 32'(burst_open), 32'd0);

    // Reset at beat 2 discards the partial burst; next burst frames from zero
    start_reset();
    for (int i = 0; i < 8; i++) push(DW'(16'h0020 + i));
    release_reset();
    enable = 1'b1;
    wait_beats(2, 20, "rst_pre");
    rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid", 32'(m_valid), 32'd0);
    check("rst_mid_data", 32'(m_data), 32'd0);
    check("rst_mid_last", 32'(m_last), 32'd0);
    check("rst_mid_open", 32'(burst_open), 32'd0);
    check("rst_mid_rd_en", 32'(fifo_rd_en), 32'd0);
    release_reset();
    base = rd_ptr;
    rem  = wr_ptr - rd_ptr;
    wait_beats(int'(rem), 120, "rst_post_count");
    for (int i = 0; i < int'(rem); i++) begin
      check($sformatf("rst_post_d%0d", i), 32'(got_data[i]), 32'(mem[base + 8'(i)]));
      check($sformatf("rst_post_l%0d", i), 32'(got_last[i]),
            32'((i % BL == BL - 1) || (i == int'(rem) - 1)));
    end

    // Random traffic: mode 0 toggles m_ready each cycle, mode 1 randomises it
    for (int mode = 0; mode < 2; mode++) begin
      start_reset();
      release_reset();
      enable = 1'b1;
      exp_q.delete();
      pushed = 0; gap = 0; k = 0;
      while (got_data.size() < 30 && k < 800) begin
        m_ready = (mode == 0) ? ~m_ready : 1'($urandom_range(0, 1));
        if (pushed < 30 && (gap >= 5 || $urandom_range(0, 2) == 0)) begin
          exp_q.push_back(DW'($urandom));
          push(exp_q[pushed]);
          pushed++;
          gap = 0;
        end else begin
          gap++;
        end
        @(posedge clk); #1;
        k++;
      end
      check($sformatf("rnd%0d_count", mode), 32'(got_data.size()), 32'd30);
      for (int i = 0; i < 30; i++) begin
        check($sformatf("rnd%0d_d%0d", mode, i), 32'(got_data[i]), 32'(exp_q[i]));
        check($sformatf("rnd%0d_l%0d", mode, i), 32'(got_last[i]),
              32'((i % BL == BL - 1) || (i == 29)));
      end
    end

`ifdef FIFO_BURST_READER_STATS_EN
    start_reset();
    for (int i = 0; i < 8; i++) push(DW'(16'h0040 + i));
    release_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    wait_beats(8, 40, "stats_full");
    push(16'h0050);
    wait_beats(9, 80, "stats_tail");
    @(posedge clk); #1;
    check("stats_bursts", burst_count, 32'd3);
    check("stats_timeouts", timeout_count, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
